// File: rtl/lsu.sv
// Load/store unit: one data-memory access per request over a valid/ready bus.
// Lane steering for stores and extract/extend for loads; bad requests answer without a bus access.
module lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer occurs on a rising edge where valid && ready are both high;
   // valid and payload stay stable until then, and rsp_valid is never backpressured.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wmask_q, mem_wmask_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic        illegal;
   logic        misaligned;
   logic [31:0] shifted;
   logic [31:0] extracted;

   always_comb begin
      illegal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = req_we;
         default:                illegal = 1'b1;
      endcase
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   // Load field selection uses the offset captured at acceptance.
   always_comb begin
      shifted   = mem_rdata >> {off_q, 3'b000};
      extracted = 32'd0;
      case (funct3_q)
         3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
         3'b010:  extracted = shifted;
         3'b100:  extracted = {24'd0, shifted[7:0]};
         3'b101:  extracted = {16'd0, shifted[15:0]};
         default: extracted = 32'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d        = req_we;
               funct3_d    = req_funct3;
               off_d       = req_addr[1:0];
               rsp_rdata_d = 32'd0;
               rsp_err_d   = illegal || misaligned;
               if (illegal || misaligned) begin
                  state_d = S_RESP;
               end else begin
                  state_d    = S_REQ;
                  mem_addr_d = {req_addr[31:2], 2'b00};
                  mem_we_d   = req_we;
                  case (req_funct3[1:0])
                     2'b00: begin
                        mem_wdata_d = {4{req_wdata[7:0]}};
                        mem_wmask_d = 4'b0001 << req_addr[1:0];
                     end
                     2'b01: begin
                        mem_wdata_d = {2{req_wdata[15:0]}};
                        mem_wmask_d = 4'b0011 << {req_addr[1], 1'b0};
                     end
                     default: begin
                        mem_wdata_d = req_wdata;
                        mem_wmask_d = 4'b1111;
                     end
                  endcase
                  if (!req_we) mem_wmask_d = 4'b0000;
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               state_d = S_RESP;
               if (!we_q) rsp_rdata_d = extracted;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'd0;
         off_q       <= 2'd0;
         mem_addr_q  <= 32'd0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= 32'd0;
         mem_wmask_q <= 4'd0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign mem_req_valid = (state_q == S_REQ);
   assign rsp_valid     = (state_q == S_RESP);
   assign mem_addr      = mem_addr_q;
   assign mem_we        = mem_we_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wmask     = mem_wmask_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases from the plan plus randomized operations,
// checked against an arithmetic reference model of the load/store rules.
module tb_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   lsu dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: access rules expressed with plain arithmetic.
   function automatic void ref_model(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rdata, output logic err,
                                     output logic [31:0] ewdata, output logic [3:0] emask,
                                     output logic [31:0] erdata);
      int unsigned off;
      int unsigned size;
      logic legal;
      logic mis;
      logic [31:0] v;
      off  = addr % 4;
      size = f3 % 4;
      legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (!we && (f3 == 4 || f3 == 5));
      mis = (size == 1 && (addr % 2) != 0) || (size == 2 && off != 0);
      err = !legal || mis;
      v = rdata >> (8 * off);
      if (size == 0) begin
         v = v % 256;
         if (f3 < 4 && v >= 128) v = v - 256;
      end else if (size == 1) begin
         v = v % 65536;
         if (f3 < 4 && v >= 32768) v = v - 65536;
      end
      erdata = (err || we) ? 32'd0 : v;
      if (size == 0) begin
         ewdata = wdata[7:0] * 32'h01010101;
         emask  = 4'(1 << off);
      end else if (size == 1) begin
         ewdata = wdata[15:0] * 32'h00010001;
         emask  = 4'(3 << off);
      end else begin
         ewdata = wdata;
         emask  = 4'hF;
      end
      if (!we) emask = 4'h0;
   endfunction

   // Runs one operation with the given memory stalls; every cycle is checked at the negedge.
   task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int req_stall, input int rsp_stall,
                        input logic spurious);
      logic        e_err;
      logic [31:0] e_wd;
      logic [3:0]  e_mask;
      logic [31:0] e_rd;
      ref_model(we, f3, addr, wdata, rdata, e_err, e_wd, e_mask, e_rd);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_ready: got %b want 0", name, req_ready);
      end
      if (!e_err) begin
         for (int i = 0; i <= req_stall; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || rsp_valid !== 1'b0 || mem_addr !== {addr[31:2], 2'b00}
                || mem_we !== we || mem_wmask !== e_mask || (we && mem_wdata !== e_wd)) begin
               errors++;
               $display("FAIL %s req_phase[%0d]: mrv=%b rv=%b addr=%h we=%b wd=%h mask=%b want addr=%h we=%b wd=%h mask=%b",
                        name, i, mem_req_valid, rsp_valid, mem_addr, mem_we, mem_wdata, mem_wmask,
                        {addr[31:2], 2'b00}, we, e_wd, e_mask);
            end
            mem_req_ready = (i == req_stall);
            mem_rsp_valid = spurious && (i < req_stall);
            mem_rdata = $urandom;
            @(negedge clk);
         end
         mem_req_ready = 1'b0;
         for (int i = 0; i <= rsp_stall; i++) begin
            checks++;
            if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
               errors++;
               $display("FAIL %s wait_phase[%0d]: mrv=%b rv=%b want 0 0", name, i, mem_req_valid, rsp_valid);
            end
            mem_rsp_valid = (i == rsp_stall);
            mem_rdata = (i == rsp_stall) ? rdata : $urandom;
            @(negedge clk);
         end
         mem_rsp_valid = 1'b0;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== e_err || rsp_rdata !== e_rd || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s response: rv=%b err=%b rdata=%h mrv=%b want 1 %b %h 0",
                  name, rsp_valid, rsp_err, rsp_rdata, mem_req_valid, e_err, e_rd);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after_resp: rv=%b ready=%b want 0 1", name, rsp_valid, req_ready);
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0
          || mem_wdata !== 32'd0 || mem_wmask !== 4'd0 || rsp_valid !== 1'b0
          || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL %s reset_values: ready=%b mrv=%b we=%b addr=%h wd=%h mask=%b rv=%b rd=%h err=%b",
                  name, req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
                  rsp_valid, rsp_rdata, rsp_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      check_reset_values("reset_hold");
      rst_n = 1'b1;
   endtask

   task automatic test_loads();
      do_op("lw",  1'b0, 3'b010, 32'h80000010, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
      do_op("lb",  1'b0, 3'b000, 32'h80000013, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
      do_op("lbu", 1'b0, 3'b100, 32'h80000013, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
      do_op("lhu", 1'b0, 3'b101, 32'h80000012, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
      do_op("lh",  1'b0, 3'b001, 32'h80000012, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
   endtask

   task automatic test_stores();
      do_op("sb", 1'b1, 3'b000, 32'h00000021, 32'h123456AB, 32'hFFFFFFFF, 0, 0, 1'b0);
      do_op("sh", 1'b1, 3'b001, 32'h00000022, 32'h9876CAFE, 32'h55555555, 0, 1, 1'b0);
      do_op("sw", 1'b1, 3'b010, 32'h00000040, 32'hA5A55A5A, 32'h12345678, 1, 0, 1'b0);
   endtask

   task automatic test_errors();
      do_op("sh_misaligned", 1'b1, 3'b001, 32'h00000001, 32'h1111, 32'h0, 0, 0, 1'b0);
      do_op("lw_misaligned", 1'b0, 3'b010, 32'h00000002, 32'h0, 32'h0, 0, 0, 1'b0);
      do_op("store_f3_100",  1'b1, 3'b100, 32'h00000000, 32'h77, 32'h0, 0, 0, 1'b0);
      do_op("load_f3_111",   1'b0, 3'b111, 32'h00000000, 32'h0, 32'h0, 0, 0, 1'b0);
   endtask

   task automatic test_stall();
      do_op("req_stall", 1'b0, 3'b000, 32'h10000003, 32'h0, 32'h7F000000, 4, 2, 1'b1);
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00000100;
      @(negedge clk);
      req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      checks++;
      if (dbg_state !== 2'd2 || mem_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait precondition: state=%0d mrv=%b rv=%b want 2 0 0", dbg_state, mem_req_valid, rsp_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("rst_mid_wait");
      @(negedge clk);
      check_reset_values("rst_mid_wait_hold");
      #2 rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait no_rsp: rv=%b want 0", rsp_valid);
         end
      end
      do_op("after_reset_lw", 1'b0, 3'b010, 32'h00000104, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [2:0] f3;
         logic       we;
         logic [31:0] a;
         we = $urandom_range(0, 1);
         f3 = (n % 5 == 4) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
         if (!we && n % 3 == 0) f3 = 3'($urandom_range(4, 5));
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : (f3[1:0] == 2'b01) ? {a[1], 1'b0} : a[1:0];
         do_op("random", we, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_back_to_back();
      do_op("b2b_0", 1'b1, 3'b010, 32'h00000200, 32'h01020304, 32'h0, 0, 0, 1'b0);
      do_op("b2b_1", 1'b0, 3'b000, 32'h00000201, 32'h0, 32'h0000C300, 0, 0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_stall();
      test_reset_mid_wait();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
